vesa_mode_ctrl: RTL
===================

Name: vesa_mode_ctrl

Overview:
- Mode controller for the VESA timing generator. Owns all ten timing-parameter inputs of the generator (H/V total, active, front/back porch, sync).
- Accepts mode-change requests through a req/ack handshake, looks the mode up in an internal table, and blanks video output.
- Commits the new parameters only at a frame start (falling edge of the generator's Vsync), then keeps video blanked for a settle period.

Parameters:
- DEF_MODE, 2, table index driven after reset (0..2).
- SETTLE_FRAMES, 2, Vsync falling edges counted after a load before video is enabled (0..15).
- TIMEOUT_CYCLES, 4194304, WAIT_VS watchdog limit (optional feature only; counter width 23).

Ports:
- InPixClk  in  1  pixel clock; the only clock.
- InRstN  in  1  reset; synchronous, active-low.
- InVsync  in  1  Vsync fed back from the timing generator.
- InModeReq  in  1  mode request level; held until OutModeAck or OutModeErr.
- InModeSel  in  2  requested mode index.
- OutModeAck  out  1  1-cycle pulse: request accepted.
- OutModeErr  out  1  1-cycle pulse: request rejected (InModeSel=3).
- OutBusy  out  1  high whenever state is not RUN.
- OutVideoEn  out  1  downstream ANDs this with the pixel-valid signal.
- OutCurMode  out  2  index of the committed mode.
- OutVesaHtt/Hft/Hat/Hbt/Hst  out  12/7/12/8/6  horizontal timing fields.
- OutVesaVtt/Vat/Vst/Vbt/Vft  out  11/11/3/6/3  vertical timing fields.

Behaviour:
- Mode table (Htt,Hft,Hat,Hbt,Hst / Vtt,Vat,Vst,Vbt,Vft). Htt/Vtt are total-1, Hst/Vst are sync-1, others are literal:
  - 0 = 1280x720: 1649,110,1280,220,39 / 749,720,4,20,5
  - 1 = 1920x1080: 2199,88,1920,148,43 / 1124,1080,4,36,4
  - 2 = sim mode: 19,4,12,2,1 / 9,6,0,1,2
  - 3 = invalid.
- Vsync edge detection: InVsync is registered once; vs_fall = prev & ~InVsync.
- Reset (InRstN=0 at clock edge):
  - Timing outputs = DEF_MODE entry; OutCurMode = DEF_MODE.
  - OutVideoEn=0, Ack/Err=0, state=SETTLE, settle count=0.
  - Reset in any state abandons a pending request.
- RUN:
  - OutVideoEn=1, OutBusy=0.
  - InModeReq with Sel<=2: OutModeAck pulses next cycle.
    - Sel == OutCurMode: stay in RUN; no reload, no blanking.
    - Otherwise: go to WAIT_VS; OutVideoEn=0 in the same cycle as Ack; selection latched.
  - InModeReq with Sel=3: OutModeErr pulses next cycle; state unchanged.
  - The requester must deassert InModeReq the cycle after it sees Ack or Err.
- WAIT_VS: wait for vs_fall, then go to LOAD. Timing outputs are unchanged while waiting.
- LOAD: one cycle.
  - All ten timing outputs and OutCurMode update together from the latched selection.
  - Goes to SETTLE, or to RUN if SETTLE_FRAMES=0.
- SETTLE:
  - Counts vs_fall events.
  - When the count reaches SETTLE_FRAMES: count clears, go to RUN; OutVideoEn=1 the following cycle.
- Request arriving in a non-RUN state: not acknowledged. It is evaluated on the first RUN cycle.
- vs_fall coincident with the transition into WAIT_VS is not used; only an edge seen while in WAIT_VS counts.
- Timing outputs never change outside LOAD and reset.

Optional Feature:
- Macro VESA_MODE_CTRL_TIMEOUT_EN.
- Defined:
  - A 23-bit counter runs in WAIT_VS.
  - On reaching TIMEOUT_CYCLES-1 without vs_fall, the block forces LOAD. This covers a stalled or never-started generator.
  - The counter clears on leaving WAIT_VS.
- Undefined: no counter; WAIT_VS waits indefinitely.

Test Plan:
1. Reset, DEF_MODE=2, SETTLE_FRAMES=2, sim-mode generator -> Htt=19, Vtt=9, OutCurMode=2, VideoEn=0, Busy=1. Busy=0 and VideoEn=1 after the second Vsync fall.
2. RUN, Req with Sel=0 -> Ack 1 cycle; VideoEn=0; outputs hold until the next Vsync fall. Then Htt=1649, Hat=1280, Vtt=749, Vat=720, OutCurMode=0. VideoEn=1 after 2 further falls.
3. Sel=3 -> Err 1 cycle, no Ack; outputs, VideoEn and OutCurMode unchanged. Sel=OutCurMode -> Ack, no blanking, no reload.
4. Req with Sel=1 asserted during SETTLE -> no Ack until RUN. Ack on the first RUN cycle; the full sequence runs, ending with Htt=2199, Vtt=1124.
5. InRstN=0 for 1 cycle while in WAIT_VS (Sel=0 pending) -> outputs return to mode 2; request dropped; reset settle sequence repeats.
6. Macro defined, TIMEOUT_CYCLES=100, InVsync held 1 -> LOAD occurs exactly 100 cycles after entering WAIT_VS. Macro undefined -> still in WAIT_VS after 10000 cycles.

Source files
------------

// File: rtl/vesa_mode_ctrl.sv
// vesa_mode_ctrl -- mode controller for the VESA timing generator.
//
// Owns the ten timing-parameter inputs of the generator. A mode change is
// requested with a level req (InModeReq + InModeSel) that the controller
// acknowledges (OutModeAck) or rejects (OutModeErr) with a one-cycle pulse.
// Video is blanked as soon as a real change is accepted. The new table entry
// is committed only at a frame start (falling edge of InVsync). Video stays
// blanked for SETTLE_FRAMES further frame starts.
//
// Handshake: InModeReq is a level held by the requester until it sees
// OutModeAck or OutModeErr, and dropped the cycle after. Requests are only
// evaluated in RUN. While an Ack/Err pulse is high the request is ignored, so
// one held request is never accepted twice.
//
// Ports:
//   InPixClk              pixel clock, the only clock
//   InRstN                synchronous active-low reset
//   InVsync               Vsync fed back from the timing generator
//   InModeReq/InModeSel   mode request level and requested index
//   OutModeAck/OutModeErr one-cycle accept / reject pulses
//   OutBusy               high whenever the FSM is not in RUN
//   OutVideoEn            video enable for downstream pixel-valid gating
//   OutCurMode            index of the committed mode
//   OutVesaH*/OutVesaV*   timing fields (totals and syncs are value-1)
//
// Optional feature (macro VESA_MODE_CTRL_TIMEOUT_EN): a 23-bit watchdog in
// WAIT_VS forces LOAD after TIMEOUT_CYCLES cycles without a Vsync fall.
module vesa_mode_ctrl #(
    parameter int DEF_MODE      = 2,
    parameter int SETTLE_FRAMES = 2
`ifdef VESA_MODE_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4194304
`endif
) (
    input  logic        InPixClk,
    input  logic        InRstN,
    input  logic        InVsync,
    input  logic        InModeReq,
    input  logic [1:0]  InModeSel,
    output logic        OutModeAck,
    output logic        OutModeErr,
    output logic        OutBusy,
    output logic        OutVideoEn,
    output logic [1:0]  OutCurMode,
    output logic [11:0] OutVesaHtt,
    output logic [6:0]  OutVesaHft,
    output logic [11:0] OutVesaHat,
    output logic [7:0]  OutVesaHbt,
    output logic [5:0]  OutVesaHst,
    output logic [10:0] OutVesaVtt,
    output logic [10:0] OutVesaVat,
    output logic [2:0]  OutVesaVst,
    output logic [5:0]  OutVesaVbt,
    output logic [2:0]  OutVesaVft
);

    typedef enum logic [1:0] {RUN, WAIT_VS, LOAD, SETTLE} state_t;

    typedef struct packed {
        logic [11:0] htt;
        logic [6:0]  hft;
        logic [11:0] hat;
        logic [7:0]  hbt;
        logic [5:0]  hst;
        logic [10:0] vtt;
        logic [10:0] vat;
        logic [2:0]  vst;
        logic [5:0]  vbt;
        logic [2:0]  vft;
    } timing_t;

    localparam logic [1:0] DEF_IDX     = 2'(DEF_MODE);
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_FRAMES == 0) ? 0 : SETTLE_FRAMES - 1);
`ifdef VESA_MODE_CTRL_TIMEOUT_EN
    localparam logic [22:0] TO_LAST    = 23'(TIMEOUT_CYCLES - 1);
`endif

    // Index 3 is never loaded (rejected at request time); it maps to zeros.
    function automatic timing_t modeLut(input logic [1:0] idx);
        timing_t t;
        case (idx)
            2'd0:    t = '{htt: 12'd1649, hft: 7'd110, hat: 12'd1280, hbt: 8'd220, hst: 6'd39,
                           vtt: 11'd749,  vat: 11'd720, vst: 3'd4, vbt: 6'd20, vft: 3'd5};
            2'd1:    t = '{htt: 12'd2199, hft: 7'd88,  hat: 12'd1920, hbt: 8'd148, hst: 6'd43,
                           vtt: 11'd1124, vat: 11'd1080, vst: 3'd4, vbt: 6'd36, vft: 3'd4};
            2'd2:    t = '{htt: 12'd19,   hft: 7'd4,   hat: 12'd12,   hbt: 8'd2,   hst: 6'd1,
                           vtt: 11'd9,    vat: 11'd6,   vst: 3'd0, vbt: 6'd1,  vft: 3'd2};
            default: t = '0;
        endcase
        return t;
    endfunction

    state_t      state, nextState;
    timing_t     timingQ;
    logic [1:0]  curMode, selQ, nextSel;
    logic [3:0]  settleCnt, nextSettleCnt;
    logic        vsPrev, vsFall;
    logic        ackQ, errQ, ackD, errD, loadEn, videoEnQ;
`ifdef VESA_MODE_CTRL_TIMEOUT_EN
    logic [22:0] toCnt, nextToCnt;
`endif

    // Single registration of Vsync; a frame start is a 1->0 transition.
    always_ff @(posedge InPixClk) begin
        vsPrev <= InVsync;
    end
    assign vsFall = vsPrev & ~InVsync;

    always_comb begin
        nextState     = state;
        nextSel       = selQ;
        nextSettleCnt = settleCnt;
        ackD          = 1'b0;
        errD          = 1'b0;
        loadEn        = 1'b0;
`ifdef VESA_MODE_CTRL_TIMEOUT_EN
        nextToCnt     = '0;
`endif
        case (state)
            RUN: begin
                if (InModeReq && !ackQ && !errQ) begin
                    if (InModeSel == 2'd3) begin
                        errD = 1'b1;
                    end else begin
                        ackD = 1'b1;
                        // Re-selecting the committed mode is acknowledged
                        // without blanking or reloading.
                        if (InModeSel != curMode) begin
                            nextState = WAIT_VS;
                            nextSel   = InModeSel;
                        end
                    end
                end
            end
            WAIT_VS: begin
                if (vsFall) nextState = LOAD;
`ifdef VESA_MODE_CTRL_TIMEOUT_EN
                else if (toCnt == TO_LAST) nextState = LOAD;
                else nextToCnt = toCnt + 23'd1;
`endif
            end
            LOAD: begin
                loadEn        = 1'b1;
                nextSettleCnt = '0;
                nextState     = (SETTLE_FRAMES == 0) ? RUN : SETTLE;
            end
            SETTLE: begin
                if (SETTLE_FRAMES == 0) begin
                    nextState = RUN;
                end else if (vsFall) begin
                    if (settleCnt == SETTLE_LAST) begin
                        nextSettleCnt = '0;
                        nextState     = RUN;
                    end else begin
                        nextSettleCnt = settleCnt + 4'd1;
                    end
                end
            end
            default: nextState = SETTLE;
        endcase
    end

    always_ff @(posedge InPixClk) begin
        if (!InRstN) begin
            state     <= SETTLE;
            settleCnt <= '0;
            selQ      <= DEF_IDX;
            curMode   <= DEF_IDX;
            timingQ   <= modeLut(DEF_IDX);
            videoEnQ  <= 1'b0;
            ackQ      <= 1'b0;
            errQ      <= 1'b0;
`ifdef VESA_MODE_CTRL_TIMEOUT_EN
            toCnt     <= '0;
`endif
        end else begin
            state     <= nextState;
            settleCnt <= nextSettleCnt;
            selQ      <= nextSel;
            ackQ      <= ackD;
            errQ      <= errD;
            // Video is on exactly while the FSM sits in RUN.
            videoEnQ  <= (nextState == RUN);
            if (loadEn) begin
                timingQ <= modeLut(selQ);
                curMode <= selQ;
            end
`ifdef VESA_MODE_CTRL_TIMEOUT_EN
            toCnt     <= nextToCnt;
`endif
        end
    end

    assign OutModeAck = ackQ;
    assign OutModeErr = errQ;
    assign OutBusy    = (state != RUN);
    assign OutVideoEn = videoEnQ;
    assign OutCurMode = curMode;
    assign OutVesaHtt = timingQ.htt;
    assign OutVesaHft = timingQ.hft;
    assign OutVesaHat = timingQ.hat;
    assign OutVesaHbt = timingQ.hbt;
    assign OutVesaHst = timingQ.hst;
    assign OutVesaVtt = timingQ.vtt;
    assign OutVesaVat = timingQ.vat;
    assign OutVesaVst = timingQ.vst;
    assign OutVesaVbt = timingQ.vbt;
    assign OutVesaVft = timingQ.vft;

endmodule
